// File: rtl/reg_dst_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_dst_scoreboard
//   Issue-stage hazard controller. Selects the destination register field of
//   the decoded instruction, tracks outstanding register writes in a 64-entry
//   pending scoreboard, and stalls issue on RAW/WAW hazards or when the
//   outstanding-write limit is reached. Writebacks retire entries.
//
// Ports
//   Clock_i, Reset_i      rising-edge clock, synchronous active-high reset
//   Issue_Valid_i         decoded instruction presented this cycle
//   Src_A_i, Src_B_i      source registers; Use_Src_B_i qualifies Src_B
//   Reg_20_15_i/14_09_i   candidate destination fields, picked by Reg_Dest_i
//   Reg_Write_i           instruction writes a register
//   WB_Valid_i/Register_i writeback retiring a write this cycle
//   Issue_Stall_o         combinational: hold the instruction
//   Issue_Accept_o        combinational: Issue_Valid & ~Issue_Stall
//   Write_Register_o      destination of the last accepted writing instruction
//   Pending_Count_o       number of outstanding writes
//   Busy_o                Pending_Count != 0
//   WB_Error_o            sticky: writeback to a non-pending register seen
// ---------------------------------------------------------------------------
module reg_dst_scoreboard #(
  parameter int MAX_PENDING    = 4,
  parameter int ZERO_HARDWIRED = 1,
  localparam int CNT_W         = $clog2(MAX_PENDING + 1)
) (
  input  logic             Clock_i,
  input  logic             Reset_i,
  input  logic             Issue_Valid_i,
  input  logic [5:0]       Src_A_i,
  input  logic [5:0]       Src_B_i,
  input  logic             Use_Src_B_i,
  input  logic [5:0]       Reg_20_15_i,
  input  logic [5:0]       Reg_14_09_i,
  input  logic             Reg_Dest_i,
  input  logic             Reg_Write_i,
  input  logic             WB_Valid_i,
  input  logic [5:0]       WB_Register_i,
  output logic             Issue_Stall_o,
  output logic             Issue_Accept_o,
  output logic [5:0]       Write_Register_o,
  output logic [CNT_W-1:0] Pending_Count_o,
  output logic             Busy_o,
  output logic             WB_Error_o
);

  logic [63:0]      pend_q, pend_d, eff;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_ret;
  logic [5:0]       wreg_q, wreg_d;
  logic             err_q, err_d;

  logic [5:0] dest;
  logic       wb_zero, wb_hit, wb_miss;
  logic       raw_a, raw_b, waw, full, set_dest;

  // Register 0 is invisible to the scoreboard when hardwired.
  function automatic logic is_zero(input logic [5:0] r);
    return (ZERO_HARDWIRED != 0) && (r == 6'd0);
  endfunction

  assign dest    = Reg_Dest_i ? Reg_20_15_i : Reg_14_09_i;

  assign wb_zero = is_zero(WB_Register_i);
  assign wb_hit  = WB_Valid_i & ~wb_zero &  pend_q[WB_Register_i];
  assign wb_miss = WB_Valid_i & ~wb_zero & ~pend_q[WB_Register_i];

  // Same-cycle writeback bypass: the retiring register is already free for
  // hazard checks, and its slot already counts as released.
  assign eff     = pend_q & ~(64'(wb_hit) << WB_Register_i);
  assign cnt_ret = cnt_q - CNT_W'(wb_hit);

  assign raw_a = eff[Src_A_i] & ~is_zero(Src_A_i);
  assign raw_b = Use_Src_B_i & eff[Src_B_i] & ~is_zero(Src_B_i);
  assign waw   = Reg_Write_i & eff[dest] & ~is_zero(dest);
  assign full  = Reg_Write_i & (cnt_ret == CNT_W'(MAX_PENDING));

  assign Issue_Stall_o  = Issue_Valid_i & (raw_a | raw_b | waw | full);
  assign Issue_Accept_o = Issue_Valid_i & ~Issue_Stall_o;

  // A write to hardwired r0 issues but leaves no trace in the scoreboard.
  assign set_dest = Issue_Accept_o & Reg_Write_i & ~is_zero(dest);

  // Issue is applied after the retire, so a register retired and re-issued
  // in the same cycle ends up pending with the count unchanged.
  always_comb begin
    pend_d = eff;
    cnt_d  = cnt_ret;
    wreg_d = wreg_q;
    err_d  = err_q | wb_miss;
    if (set_dest) begin
      pend_d = eff | (64'd1 << dest);
      cnt_d  = cnt_ret + CNT_W'(1);
      wreg_d = dest;
    end
  end

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
      wreg_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      wreg_q <= wreg_d;
      err_q  <= err_d;
    end
  end

  assign Write_Register_o = wreg_q;
  assign Pending_Count_o  = cnt_q;
  assign Busy_o           = (cnt_q != '0);
  assign WB_Error_o       = err_q;

endmodule

// File: tb/tb_reg_dst_scoreboard.sv
module tb_reg_dst_scoreboard;
  localparam int MAXP = 4;

  logic       Clock_i = 1'b0, Reset_i;
  logic       Issue_Valid_i, Use_Src_B_i, Reg_Dest_i, Reg_Write_i, WB_Valid_i;
  logic [5:0] Src_A_i, Src_B_i, Reg_20_15_i, Reg_14_09_i, WB_Register_i;
  logic       Issue_Stall_o, Issue_Accept_o, Busy_o, WB_Error_o;
  logic [5:0] Write_Register_o;
  logic [2:0] Pending_Count_o;

  int n_chk = 0;
  int n_fail = 0;

  reg_dst_scoreboard #(.MAX_PENDING(MAXP), .ZERO_HARDWIRED(1)) dut (
    .Clock_i(Clock_i), .Reset_i(Reset_i), .Issue_Valid_i(Issue_Valid_i),
    .Src_A_i(Src_A_i), .Src_B_i(Src_B_i), .Use_Src_B_i(Use_Src_B_i),
    .Reg_20_15_i(Reg_20_15_i), .Reg_14_09_i(Reg_14_09_i), .Reg_Dest_i(Reg_Dest_i),
    .Reg_Write_i(Reg_Write_i), .WB_Valid_i(WB_Valid_i), .WB_Register_i(WB_Register_i),
    .Issue_Stall_o(Issue_Stall_o), .Issue_Accept_o(Issue_Accept_o),
    .Write_Register_o(Write_Register_o), .Pending_Count_o(Pending_Count_o),
    .Busy_o(Busy_o), .WB_Error_o(WB_Error_o));

  always #5 Clock_i = ~Clock_i;

  // ---- stimulus helpers (inputs change 1 time unit after the rising edge) ----
  task automatic idle();
    Reset_i = 0; Issue_Valid_i = 0; Src_A_i = 0; Src_B_i = 0; Use_Src_B_i = 0;
    Reg_20_15_i = 0; Reg_14_09_i = 0; Reg_Dest_i = 0; Reg_Write_i = 0;
    WB_Valid_i = 0; WB_Register_i = 0;
  endtask

  task automatic tick();
    @(posedge Clock_i); #1;
  endtask

  task automatic do_reset();
    idle(); Reset_i = 1; tick(); Reset_i = 0;
  endtask

  // write instruction to register r via the 20:15 field, no sources
  task automatic set_write(input logic [5:0] r);
    idle(); Issue_Valid_i = 1; Reg_Write_i = 1; Reg_Dest_i = 1; Reg_20_15_i = r;
    Reg_14_09_i = 6'd9;
  endtask

  // ---- directed tests ----
  task automatic test_reset();
    do_reset(); #1;
    n_chk++; if (Pending_Count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", Pending_Count_o); end
    n_chk++; if (Write_Register_o !== 6'd0) begin n_fail++; $display("FAIL reset_wreg got %0d want 0", Write_Register_o); end
    n_chk++; if (Busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", Busy_o); end
    n_chk++; if (WB_Error_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", WB_Error_o); end
    n_chk++; if (Issue_Stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", Issue_Stall_o); end
  endtask

  task automatic test_issue_and_bypass();
    do_reset();
    set_write(6'd5); #1;
    n_chk++; if (Issue_Accept_o !== 1'b1) begin n_fail++; $display("FAIL first_accept got %b want 1", Issue_Accept_o); end
    tick();
    n_chk++; if (Write_Register_o !== 6'd5) begin n_fail++; $display("FAIL first_wreg got %0d want 5", Write_Register_o); end
    n_chk++; if (Pending_Count_o !== 3'd1) begin n_fail++; $display("FAIL first_count got %0d want 1", Pending_Count_o); end
    n_chk++; if (Busy_o !== 1'b1) begin n_fail++; $display("FAIL first_busy got %b want 1", Busy_o); end
    // RAW on R5 until it is written back
    idle(); Issue_Valid_i = 1; Src_A_i = 6'd5;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++; if (Issue_Stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_stall cyc %0d got %b want 1", c, Issue_Stall_o); end
      tick();
    end
    // Src_B not read -> no hazard
    Src_A_i = 6'd0; Src_B_i = 6'd5; Use_Src_B_i = 0; #1;
    n_chk++; if (Issue_Accept_o !== 1'b1) begin n_fail++; $display("FAIL srcb_unused got %b want 1", Issue_Accept_o); end
    Use_Src_B_i = 1; #1;
    n_chk++; if (Issue_Stall_o !== 1'b1) begin n_fail++; $display("FAIL srcb_raw got %b want 1", Issue_Stall_o); end
    WB_Valid_i = 1; WB_Register_i = 6'd5; #1;
    n_chk++; if (Issue_Accept_o !== 1'b1) begin n_fail++; $display("FAIL bypass_accept got %b want 1", Issue_Accept_o); end
    tick(); idle(); #1;
    n_chk++; if (Pending_Count_o !== 3'd0) begin n_fail++; $display("FAIL bypass_count got %0d want 0", Pending_Count_o); end
    n_chk++; if (Busy_o !== 1'b0) begin n_fail++; $display("FAIL bypass_busy got %b want 0", Busy_o); end
  endtask

  task automatic test_waw();
    do_reset();
    idle(); Issue_Valid_i = 1; Reg_Write_i = 1; Reg_Dest_i = 0; Reg_14_09_i = 6'd12; Reg_20_15_i = 6'd33;
    tick(); #1;
    n_chk++; if (Issue_Stall_o !== 1'b1) begin n_fail++; $display("FAIL waw_stall got %b want 1", Issue_Stall_o); end
    Reg_Write_i = 0; #1;
    n_chk++; if (Issue_Accept_o !== 1'b1) begin n_fail++; $display("FAIL nowrite_accept got %b want 1", Issue_Accept_o); end
    tick();
    n_chk++; if (Write_Register_o !== 6'd12) begin n_fail++; $display("FAIL nowrite_wreg got %0d want 12", Write_Register_o); end
    n_chk++; if (Pending_Count_o !== 3'd1) begin n_fail++; $display("FAIL nowrite_count got %0d want 1", Pending_Count_o); end
    // retire and re-issue the same register in one cycle
    Reg_Write_i = 1; WB_Valid_i = 1; WB_Register_i = 6'd12; #1;
    n_chk++; if (Issue_Accept_o !== 1'b1) begin n_fail++; $display("FAIL reissue_accept got %b want 1", Issue_Accept_o); end
    tick(); idle(); Issue_Valid_i = 1; Src_A_i = 6'd12; #1;
    n_chk++; if (Pending_Count_o !== 3'd1) begin n_fail++; $display("FAIL reissue_count got %0d want 1", Pending_Count_o); end
    n_chk++; if (Issue_Stall_o !== 1'b1) begin n_fail++; $display("FAIL reissue_pending got %b want 1", Issue_Stall_o); end
  endtask

  task automatic test_full();
    logic [5:0] r;
    do_reset();
    for (int i = 1; i <= 4; i++) begin set_write(6'(i)); tick(); end
    n_chk++; if (Pending_Count_o !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", Pending_Count_o); end
    set_write(6'd6); #1;
    n_chk++; if (Issue_Stall_o !== 1'b1) begin n_fail++; $display("FAIL full_stall got %b want 1", Issue_Stall_o); end
    WB_Valid_i = 1; WB_Register_i = 6'd2; #1;
    n_chk++; if (Issue_Accept_o !== 1'b1) begin n_fail++; $display("FAIL full_wb_accept got %b want 1", Issue_Accept_o); end
    tick();
    n_chk++; if (Pending_Count_o !== 3'd4) begin n_fail++; $display("FAIL full_net_count got %0d want 4", Pending_Count_o); end
    n_chk++; if (Write_Register_o !== 6'd6) begin n_fail++; $display("FAIL full_wreg got %0d want 6", Write_Register_o); end
    for (int i = 1; i <= 6; i++) begin
      r = 6'(i);
      idle(); Issue_Valid_i = 1; Src_A_i = r; #1;
      n_chk++;
      if (Issue_Stall_o !== (r != 6'd2 && r != 6'd5)) begin
        n_fail++; $display("FAIL full_pending r%0d got %b want %b", r, Issue_Stall_o, (r != 6'd2 && r != 6'd5));
      end
    end
  endtask

  task automatic test_wb_error();
    do_reset();
    idle(); WB_Valid_i = 1; WB_Register_i = 6'd0; tick(); idle(); #1;
    n_chk++; if (WB_Error_o !== 1'b0) begin n_fail++; $display("FAIL wb_r0_err got %b want 0", WB_Error_o); end
    WB_Valid_i = 1; WB_Register_i = 6'd7; #1;
    n_chk++; if (WB_Error_o !== 1'b0) begin n_fail++; $display("FAIL wb_err_early got %b want 0", WB_Error_o); end
    tick(); idle(); tick(); tick();
    n_chk++; if (WB_Error_o !== 1'b1) begin n_fail++; $display("FAIL wb_err_sticky got %b want 1", WB_Error_o); end
    n_chk++; if (Pending_Count_o !== 3'd0) begin n_fail++; $display("FAIL wb_err_count got %0d want 0", Pending_Count_o); end
    do_reset(); #1;
    n_chk++; if (WB_Error_o !== 1'b0) begin n_fail++; $display("FAIL wb_err_clear got %b want 0", WB_Error_o); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 1; i <= 3; i++) begin set_write(6'(i + 10)); tick(); end
    set_write(6'd20); Reset_i = 1; tick(); idle(); #1;
    n_chk++; if (Pending_Count_o !== 3'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", Pending_Count_o); end
    n_chk++; if (Write_Register_o !== 6'd0) begin n_fail++; $display("FAIL midrst_wreg got %0d want 0", Write_Register_o); end
    Issue_Valid_i = 1; Src_A_i = 6'd11; Use_Src_B_i = 1; Src_B_i = 6'd20; #1;
    n_chk++; if (Issue_Stall_o !== 1'b0) begin n_fail++; $display("FAIL midrst_clear got %b want 0", Issue_Stall_o); end
  endtask

  // ---- randomized test against a set-based reference model ----
  task automatic test_random();
    bit [63:0] mp, e;
    logic [5:0] mwr, d;
    bit merr, wb_ok, wb_bad, ex_stall, ex_acc;
    int cnt;
    do_reset();
    mp = '0; mwr = 0; merr = 0;
    for (int it = 0; it < 600; it++) begin
      idle();
      Reset_i       = ($urandom_range(0, 49) == 0);
      Issue_Valid_i = ($urandom_range(0, 3) != 0);
      Src_A_i       = 6'($urandom_range(0, 7));
      Src_B_i       = 6'($urandom_range(0, 7));
      Use_Src_B_i   = 1'($urandom);
      Reg_20_15_i   = 6'($urandom_range(0, 7));
      Reg_14_09_i   = 6'($urandom_range(0, 7));
      Reg_Dest_i    = 1'($urandom);
      Reg_Write_i   = ($urandom_range(0, 3) != 0);
      WB_Valid_i    = ($urandom_range(0, 2) == 0);
      WB_Register_i = 6'($urandom_range(0, 7));
      // model: writeback first, then hazards against the remaining set
      d      = Reg_Dest_i ? Reg_20_15_i : Reg_14_09_i;
      wb_ok  = WB_Valid_i && WB_Register_i != 0 &&  mp[WB_Register_i];
      wb_bad = WB_Valid_i && WB_Register_i != 0 && !mp[WB_Register_i];
      e = mp; if (wb_ok) e[WB_Register_i] = 1'b0;
      cnt = $countones(e);
      ex_stall = Issue_Valid_i && ((Src_A_i != 0 && e[Src_A_i]) ||
                 (Use_Src_B_i && Src_B_i != 0 && e[Src_B_i]) ||
                 (Reg_Write_i && d != 0 && e[d]) || (Reg_Write_i && cnt == MAXP));
      ex_acc = Issue_Valid_i && !ex_stall;
      #1;
      n_chk++; if (Issue_Stall_o !== ex_stall) begin n_fail++; $display("FAIL rnd_stall it %0d got %b want %b", it, Issue_Stall_o, ex_stall); end
      n_chk++; if (Issue_Accept_o !== ex_acc) begin n_fail++; $display("FAIL rnd_accept it %0d got %b want %b", it, Issue_Accept_o, ex_acc); end
      if (Reset_i) begin
        mp = '0; mwr = 0; merr = 0;
      end else begin
        mp = e;
        if (ex_acc && Reg_Write_i && d != 0) begin mp[d] = 1'b1; mwr = d; end
        if (wb_bad) merr = 1;
      end
      tick();
      n_chk++; if (Pending_Count_o !== 3'($countones(mp))) begin n_fail++; $display("FAIL rnd_count it %0d got %0d want %0d", it, Pending_Count_o, $countones(mp)); end
      n_chk++; if (Write_Register_o !== mwr) begin n_fail++; $display("FAIL rnd_wreg it %0d got %0d want %0d", it, Write_Register_o, mwr); end
      n_chk++; if (Busy_o !== (mp != 0)) begin n_fail++; $display("FAIL rnd_busy it %0d got %b want %b", it, Busy_o, (mp != 0)); end
      n_chk++; if (WB_Error_o !== merr) begin n_fail++; $display("FAIL rnd_err it %0d got %b want %b", it, WB_Error_o, merr); end
    end
  endtask

  initial begin
    idle();
    tick();
    test_reset();
    test_issue_and_bypass();
    test_waw();
    test_full();
    test_wb_error();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_dst_scoreboard.md
Name: reg_dst_scoreboard

Overview:
- Issue-stage hazard controller wrapped around destination-register selection.
- Per instruction, picks the destination field (bits 20:15 or 14:9) under Reg_Dest and tracks in-flight register writes in a 64-entry pending scoreboard.
- Stalls issue on RAW/WAW hazards or when the outstanding-write limit is reached.
- Writeback retires entries. Sits between decode and the register-file write path.

Parameters:
- MAX_PENDING, 4, maximum outstanding register writes (1..63).
- ZERO_HARDWIRED, 1, when 1 register 0 is never marked pending and never causes a hazard.

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- Issue_Valid  input  1  decoded instruction presented this cycle
- Src_A  input  6  first source register
- Src_B  input  6  second source register
- Use_Src_B  input  1  Src_B is read by this instruction
- Reg_20_15  input  6  instruction bits 20:15
- Reg_14_09  input  6  instruction bits 14:9
- Reg_Dest  input  1  1 = dest is Reg_20_15, 0 = dest is Reg_14_09
- Reg_Write  input  1  instruction writes a register
- WB_Valid  input  1  writeback retiring a write this cycle
- WB_Register  input  6  register being written back
- Issue_Stall  output  1  combinational; instruction must be held
- Issue_Accept  output  1  combinational; Issue_Valid & ~Issue_Stall
- Write_Register  output  6  registered destination of last accepted writing instruction
- Pending_Count  output  3  outstanding writes (width sized for MAX_PENDING=4; widen with parameter)
- Busy  output  1  Pending_Count != 0
- WB_Error  output  1  sticky: writeback to non-pending register seen

Behaviour:
- Reset (synchronous, Clock edge with Reset=1): all 64 pending bits 0; Write_Register=0; Pending_Count=0; WB_Error=0. Reset overrides any same-cycle issue/writeback.
- Dest = Reg_Dest ? Reg_20_15 : Reg_14_09 (combinational, internal).
- Effective pending view (eff): pending bits with WB_Register cleared when WB_Valid and that bit is set. This same-cycle writeback bypass lets an instruction issue in the cycle its source retires.
- Hazards, all evaluated only when Issue_Valid=1:
  - RAW_A = eff[Src_A].
  - RAW_B = Use_Src_B & eff[Src_B].
  - WAW = Reg_Write & eff[Dest].
  - FULL = Reg_Write & (count after same-cycle retire == MAX_PENDING).
- With ZERO_HARDWIRED=1:
  - Any comparison against register 0 is false.
  - A write to register 0 issues without setting a bit or incrementing the count.
- Issue_Stall = Issue_Valid & (RAW_A | RAW_B | WAW | FULL); 0 when Issue_Valid=0.
- On accept with Reg_Write=1 (and dest not hardwired zero):
  - Set pending[Dest].
  - Write_Register <= Dest.
  - Count +1.
- On accept with Reg_Write=0: no scoreboard change; Write_Register holds.
- Writeback, WB_Valid=1:
  - Target pending: clear the bit, count -1.
  - Target not pending: no state change, WB_Error <= 1 (sticky until Reset).
  - WB_Register=0 with ZERO_HARDWIRED=1: ignored, no error.
- Simultaneous writeback and accept:
  - Count changes by net (+1, -1, 0).
  - Same register retired and re-issued in one cycle: the bit ends set (issue wins), count unchanged.
- Count never exceeds MAX_PENDING and never underflows.
- Latency: hazard decision combinational in the issue cycle; scoreboard update visible the next cycle.
- No internal FSM beyond scoreboard and counter. The controller is idle when Busy=0.

Test Plan:
- Reset, then Issue_Valid with Reg_Write=1, Reg_Dest=1, Reg_20_15=5, Reg_14_09=9 -> Issue_Accept=1; next cycle Write_Register=5, Pending_Count=1, Busy=1.
- R5 pending; issue Src_A=5 -> Issue_Stall=1 until WB_Valid with WB_Register=5. In that WB cycle, Issue_Accept=1 (bypass); next cycle Pending_Count=0.
- Reg_Dest=0, Reg_14_09=12, R12 pending, Reg_Write=1, sources clear -> WAW stall. With Reg_Write=0 the same instruction is accepted and Write_Register is unchanged.
- Issue four writes to R1..R4 (count=4), then a fifth to R6 -> Issue_Stall=1. Same cycle WB R2 -> accepted; count stays 4; pending = {1,3,4,6}.
- WB_Valid with WB_Register=7, not pending -> WB_Error=1 from the next cycle, count unchanged; only Reset clears it. WB to R0 -> no error.
- Reset asserted mid-stream with count=3 and a simultaneous accept -> next cycle all pending bits 0, Pending_Count=0, Write_Register=0.
